usb_cdc_multi_config: RTL



---
 rtl/usb_cdc_multi_config.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/usb_cdc_multi_config.sv
// EP0 CDC-ACM class-request handler for NUM_CH UART channels: decodes line-coding,
// control-line and break requests, commits validated line coding and streams GET replies.
`timescale 1ns/1ps
module usb_cdc_multi_config #(
  parameter int          NUM_CH        = 2,
  parameter int          IF_STRIDE     = 2,
  parameter logic [3:0]  CFG_ENDPT     = 4'h0,
  parameter int unsigned DEF_BAUD      = 115200,
  parameter int          DEF_DATA_BITS = 8,
  parameter int          CLK_PER_MS    = 60000
) (
  input  logic                  PHY_CLKOUT,
  input  logic                  RESET_IN,
  input  logic                  setup_active,
  input  logic [3:0]            endpt_sel,
  input  logic                  usb_rxval,
  input  logic                  usb_rxact,
  input  logic [7:0]            usb_rxdat,
  input  logic                  usb_txact,
  input  logic                  usb_txpop,
  output logic [11:0]           usb_txdat_len_o,
  output logic [7:0]            endpt0_dat_o,
  output logic                  endpt0_send_o,
  output logic [32*NUM_CH-1:0]  baud_o,
  output logic [8*NUM_CH-1:0]   stop_o,
  output logic [8*NUM_CH-1:0]   parity_o,
  output logic [8*NUM_CH-1:0]   data_bits_o,
  output logic [NUM_CH-1:0]     dtr_o,
  output logic [NUM_CH-1:0]     rts_o,
  output logic [NUM_CH-1:0]     break_o,
  output logic [NUM_CH-1:0]     cfg_update_o,
  output logic                  cfg_err_o
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PRE_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  localparam logic [7:0] REQ_SET_LC   = 8'h20;
  localparam logic [7:0] REQ_GET_LC   = 8'h21;
  localparam logic [7:0] REQ_SET_CLS  = 8'h22;
  localparam logic [7:0] REQ_SEND_BRK = 8'h23;

  // ---------------------------------------------------------------------------
  // Setup packet capture
  // ---------------------------------------------------------------------------
  logic [7:0] setup_q [8];
  logic [3:0] setup_idx;
  logic       setup_wr;
  logic       decode;

  assign setup_wr = setup_active && usb_rxval && (setup_idx != 4'd8);
  assign decode   = setup_wr && (setup_idx == 4'd7);

  always_ff @(posedge PHY_CLKOUT) begin
    if (RESET_IN) begin
      setup_idx <= '0;
      // NOTE: this eight-byte buffer is cleared on reset like every other register; a large RAM would normally be left unreset.
      for (int i = 0; i < 8; i++) setup_q[i] <= '0;
    end else if (!setup_active) begin
      setup_idx <= '0;
    end else if (setup_wr) begin
      // NOTE: non-blocking assignments let every register in this edge see pre-edge values.
      setup_q[setup_idx[2:0]] <= usb_rxdat;
      setup_idx               <= setup_idx + 4'd1;
    end
  end

  // Decode uses the seven stored bytes plus wLength's high byte still on the bus.
  logic [7:0]      b_request;
  logic [15:0]     w_value, w_index, w_length, ch_quot;
  logic            ch_ok, req_known, dec_valid;
  logic [CH_W-1:0] dec_ch;

  always_comb begin
    // NOTE: every signal here is assigned on every path, so no latch can be inferred.
    b_request = setup_q[1];
    w_value   = {setup_q[3], setup_q[2]};
    w_index   = {setup_q[5], setup_q[4]};
    w_length  = {usb_rxdat, setup_q[6]};
    ch_quot   = w_index / 16'(IF_STRIDE);
    ch_ok     = ((w_index % 16'(IF_STRIDE)) == 16'd0) && (ch_quot < 16'(NUM_CH));
    dec_ch    = ch_quot[CH_W-1:0];
    req_known = (b_request >= REQ_SET_LC) && (b_request <= REQ_SEND_BRK);
  end

  assign dec_valid = decode && ch_ok;

  // ---------------------------------------------------------------------------
  // SET_LINE_CODING shadow buffer and validation
  // ---------------------------------------------------------------------------
  logic [7:0]      shadow [7];
  logic [2:0]      sh_cnt;
  logic            set_pend;
  logic [CH_W-1:0] set_ch;
  logic            commit_q, commit_ok;
  logic            out_wr, lc_valid;
  logic [31:0]     sh_baud;

  assign out_wr  = !setup_active && usb_rxact && (endpt_sel == CFG_ENDPT) && usb_rxval;
  assign sh_baud = {shadow[3], shadow[2], shadow[1], shadow[0]};
  assign lc_valid = (sh_baud != 32'd0) && (shadow[4] <= 8'd2) && (shadow[5] <= 8'd4) &&
                    (usb_rxdat inside {8'd5, 8'd6, 8'd7, 8'd8, 8'd16});

  always_ff @(posedge PHY_CLKOUT) begin
    if (RESET_IN) begin
      sh_cnt    <= '0;
      set_pend  <= 1'b0;
      set_ch    <= '0;
      commit_q  <= 1'b0;
      commit_ok <= 1'b0;
      for (int i = 0; i < 7; i++) shadow[i] <= '0;
    end else begin
      commit_q <= 1'b0;
      if (setup_active) begin
        sh_cnt   <= '0;
        set_pend <= 1'b0;
        if (dec_valid && (b_request == REQ_SET_LC)) begin
          set_pend <= 1'b1;
          set_ch   <= dec_ch;
        end
      end else if (out_wr && set_pend) begin
        shadow[sh_cnt] <= usb_rxdat;
        if (sh_cnt == 3'd6) begin
          set_pend  <= 1'b0;
          commit_q  <= 1'b1;
          commit_ok <= lc_valid;
        end else begin
          sh_cnt <= sh_cnt + 3'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel line coding, control lines and status pulses
  // ---------------------------------------------------------------------------
  logic [31:0]       baud_q   [NUM_CH];
  logic [7:0]        stop_q   [NUM_CH];
  logic [7:0]        parity_q [NUM_CH];
  logic [7:0]        dbits_q  [NUM_CH];
  logic [NUM_CH-1:0] dtr_q, rts_q, cfg_update_q;
  logic              cfg_err_q;

  always_ff @(posedge PHY_CLKOUT) begin
    if (RESET_IN) begin
      for (int c = 0; c < NUM_CH; c++) begin
        baud_q[c]   <= 32'(DEF_BAUD);
        stop_q[c]   <= '0;
        parity_q[c] <= '0;
        dbits_q[c]  <= 8'(DEF_DATA_BITS);
      end
      dtr_q        <= '0;
      rts_q        <= '0;
      cfg_update_q <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      cfg_update_q <= '0;
      cfg_err_q    <= 1'b0;
      if (commit_q) begin
        if (commit_ok) begin
          baud_q[set_ch]       <= sh_baud;
          stop_q[set_ch]       <= shadow[4];
          parity_q[set_ch]     <= shadow[5];
          dbits_q[set_ch]      <= shadow[6];
          cfg_update_q[set_ch] <= 1'b1;
        end else begin
          cfg_err_q <= 1'b1;
        end
      end
      if (decode && req_known && !ch_ok) cfg_err_q <= 1'b1;
      if (dec_valid && (b_request == REQ_SET_CLS)) begin
        dtr_q[dec_ch] <= w_value[0];
        rts_q[dec_ch] <= w_value[1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // GET_LINE_CODING reply stream and IN transfer length
  // ---------------------------------------------------------------------------
  logic [7:0]      tx_dat_q, tx_next;
  logic            tx_send_q;
  logic [2:0]      tx_idx;
  logic [CH_W-1:0] tx_ch;
  logic [11:0]     len_q;
  logic            tx_pop;

  assign tx_pop = usb_txact && (endpt_sel == CFG_ENDPT) && usb_txpop && tx_send_q;

  // tx_idx is the reply byte currently presented; tx_next is the one after it.
  always_comb begin
    case (tx_idx)
      3'd0:    tx_next = baud_q[tx_ch][15:8];
      3'd1:    tx_next = baud_q[tx_ch][23:16];
      3'd2:    tx_next = baud_q[tx_ch][31:24];
      3'd3:    tx_next = stop_q[tx_ch];
      3'd4:    tx_next = parity_q[tx_ch];
      default: tx_next = dbits_q[tx_ch];
    endcase
  end

  always_ff @(posedge PHY_CLKOUT) begin
    if (RESET_IN) begin
      tx_dat_q  <= '0;
      tx_send_q <= 1'b0;
      tx_idx    <= '0;
      tx_ch     <= '0;
      len_q     <= 12'd7;
    end else if (setup_active) begin
      tx_send_q <= 1'b0;
      if (decode) len_q <= (w_length < 16'd7) ? {9'd0, w_length[2:0]} : 12'd7;
      if (dec_valid && (b_request == REQ_GET_LC)) begin
        tx_send_q <= 1'b1;
        tx_dat_q  <= baud_q[dec_ch][7:0];
        tx_idx    <= '0;
        tx_ch     <= dec_ch;
      end
    end else if (tx_pop) begin
      if (tx_idx == 3'd6) begin
        tx_send_q <= 1'b0;
      end else begin
        tx_idx   <= tx_idx + 3'd1;
        tx_dat_q <= tx_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // SEND_BREAK: 0xFFFF holds, 0 releases, otherwise a timed break in ms
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] brk_q;
  logic [15:0]       ms_cnt  [NUM_CH];
  logic [PRE_W-1:0]  pre_cnt [NUM_CH];

  always_ff @(posedge PHY_CLKOUT) begin
    if (RESET_IN) begin
      brk_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        ms_cnt[c]  <= '0;
        pre_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (dec_valid && (b_request == REQ_SEND_BRK) && (dec_ch == CH_W'(c))) begin
          pre_cnt[c] <= '0;
          brk_q[c]   <= (w_value != 16'h0000);
          ms_cnt[c]  <= (w_value == 16'hFFFF) ? 16'd0 : w_value;
        end else if (ms_cnt[c] != 16'd0) begin
          if (pre_cnt[c] == PRE_W'(CLK_PER_MS - 1)) begin
            pre_cnt[c] <= '0;
            ms_cnt[c]  <= ms_cnt[c] - 16'd1;
            if (ms_cnt[c] == 16'd1) brk_q[c] <= 1'b0;
          end else begin
            pre_cnt[c] <= pre_cnt[c] + PRE_W'(1);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output packing
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    assign baud_o[32*k +: 32]     = baud_q[k];
    assign stop_o[8*k +: 8]       = stop_q[k];
    assign parity_o[8*k +: 8]     = parity_q[k];
    assign data_bits_o[8*k +: 8]  = dbits_q[k];
  end

  assign dtr_o           = dtr_q;
  assign rts_o           = rts_q;
  assign break_o         = brk_q;
  assign cfg_update_o    = cfg_update_q;
  assign cfg_err_o       = cfg_err_q;
  assign endpt0_dat_o    = tx_dat_q;
  assign endpt0_send_o   = tx_send_q;
  assign usb_txdat_len_o = len_q;

endmodule
